// File: rtl/ram_frame_reader.sv
// ram_frame_reader
//   Streams LEN consecutive bytes starting at BASE_ADDR (wrapping modulo
//   2^ADDR_W) out of one read port of a registered-output RAM. The bytes go
//   out on a valid/ready stream with a last-byte marker.
// Ports:
//   CLK, RST_N             clock, async active-low reset
//   START, BASE_ADDR, LEN  frame command (accepted only while BUSY=0)
//   BUSY, DONE             frame in progress / one-cycle completion pulse
//   RAM_ADDR, RAM_WEN      RAM read address, write enable (always 0)
//   RAM_DOUT               RAM read data, valid RD_LAT cycles after address
//   M_DATA, M_VALID,
//   M_READY, M_LAST        output byte stream
module ram_frame_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WEN,
  input  logic [DATA_W-1:0] RAM_DOUT,
  output logic [DATA_W-1:0] M_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic              M_LAST
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0]    MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]    LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [31:0]        DEPTH_U  = 32'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]     deliv_cnt_q, deliv_cnt_d;
  logic                done_q, done_d;
  logic [RD_LAT-1:0]   pipe_q, pipe_d;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    fifo_cnt_q;

  logic [ADDR_W:0]     len_c;
  logic [31:0]         used;
  logic                issue, push, pop;

  assign len_c   = (LEN > MAX_LEN) ? MAX_LEN : LEN;
  assign M_VALID = (fifo_cnt_q != '0);
  assign M_DATA  = fifo_mem_q[rd_ptr_q];
  assign M_LAST  = M_VALID && (deliv_cnt_q == LEN_ONE);
  assign BUSY    = (state_q != IDLE);
  assign DONE    = done_q;
  assign RAM_WEN = 1'b0;
  assign push    = pipe_q[RD_LAT-1];
  assign pop     = M_VALID && M_READY;
  // The issuing address goes straight out so the RAM sees it one cycle after
  // START; between issues the last issued address is held.
  assign RAM_ADDR = issue ? addr_q : ram_addr_q;

  // Credit: reads in flight plus buffered bytes never exceed the FIFO size,
  // so every byte emerging from the RAM pipe has a free slot.
  always_comb begin
    used = 32'(fifo_cnt_q);
    for (int unsigned i = 0; i < RD_LAT; i++) used = used + 32'(pipe_q[i]);
    issue = (state_q == READ) && (issue_cnt_q != '0) && (used < DEPTH_U);
  end

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = issue;
    for (int unsigned i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    deliv_cnt_d = pop ? deliv_cnt_q - LEN_ONE : deliv_cnt_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (len_c != '0) begin
            state_d     = READ;
            addr_d      = BASE_ADDR;
            issue_cnt_d = len_c;
            deliv_cnt_d = len_c;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_ONE;
          issue_cnt_d = issue_cnt_q - LEN_ONE;
          if (issue_cnt_q == LEN_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (deliv_cnt_q == LEN_ONE)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q      <= '0;
      ram_addr_q  <= '0;
      issue_cnt_q <= '0;
      deliv_cnt_q <= '0;
      done_q      <= 1'b0;
      pipe_q      <= '0;
    end else begin
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      deliv_cnt_q <= deliv_cnt_d;
      done_q      <= done_d;
      pipe_q      <= pipe_d;
      if (issue) ram_addr_q <= addr_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= RAM_DOUT;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_ONE;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_ONE;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_frame_reader.sv
module tb_ram_frame_reader;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [12:0] BASE_ADDR;
  logic [13:0] LEN;
  logic        BUSY, DONE, RAM_WEN, M_VALID, M_READY, M_LAST;
  logic [12:0] RAM_ADDR;
  logic [7:0]  RAM_DOUT, M_DATA;

  ram_frame_reader #(
    .ADDR_W(13), .DATA_W(8), .RD_LAT(2), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .RAM_ADDR(RAM_ADDR), .RAM_WEN(RAM_WEN),
    .RAM_DOUT(RAM_DOUT), .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
    .M_LAST(M_LAST)
  );

  always #5 CLK = ~CLK;

  // Two-stage registered RAM, preloaded with addr[7:0].
  logic [7:0] ram [8192];
  logic [7:0] ram_r1;
  initial for (int i = 0; i < 8192; i++) ram[i] = 8'(i);
  always @(posedge CLK) begin
    ram_r1   <= ram[RAM_ADDR];
    RAM_DOUT <= ram_r1;
  end

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard state: {last, data} per expected byte.
  logic [8:0]  exp_q [$];
  int          s0 = 0;
  int          first_rel, last_rel, done_rel;
  int          done_cnt = 0, hs_cnt = 0;
  logic        busy_seen, valid_seen;
  logic        addr_chk = 1'b0;
  logic [12:0] base_cur;
  int          n_cur;
  int          addr_bad;
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_out;

  always @(negedge CLK) begin
    int rel;
    logic [8:0]  e;
    logic [12:0] ea;
    rel = cyc - s0 + 1;
    if (!RST_N) begin
      prev_stall = 1'b0;
    end else begin
      if (BUSY) busy_seen = 1'b1;
      if (M_VALID) begin
        valid_seen = 1'b1;
        if (first_rel < 0) first_rel = rel;
      end
      if (DONE) begin
        done_cnt = done_cnt + 1;
        done_rel = rel;
        chk("busy_low_at_done", 32'(BUSY), 32'd0);
      end
      if (prev_stall) chk("stall_hold", {22'd0, M_VALID, M_LAST, M_DATA}, {22'd0, prev_out});
      if (M_VALID && M_READY) begin
        hs_cnt = hs_cnt + 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {23'd0, M_LAST, M_DATA}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("stream_byte", {23'd0, M_LAST, M_DATA}, {23'd0, e});
          if (M_LAST) last_rel = rel;
        end
      end
      prev_stall = M_VALID && !M_READY;
      prev_out   = {1'b1, M_LAST, M_DATA};
      if (addr_chk && rel >= 1 && rel <= n_cur + 1) begin
        ea = (rel <= n_cur) ? base_cur + 13'(rel - 1) : base_cur + 13'(n_cur - 1);
        if (RAM_ADDR !== ea) addr_bad = addr_bad + 1;
      end
    end
  end

  task automatic push_exp(input logic [12:0] base, input int n);
    logic [12:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 13'(i);
      exp_q.push_back({(i == n - 1), a[7:0]});
    end
  endtask

  // mode 0: M_READY=1, mode 1: random M_READY. poke_at>=0 pulses an
  // illegal START that many cycles into the frame. Negative exp_* skip.
  task automatic run_frame(input logic [12:0] base, input logic [13:0] len, input int mode,
                           input logic check_addr, input int poke_at,
                           input int exp_first, input int exp_last, input int exp_done);
    int n, d0, h0, budget, k;
    n = (len > 14'd8192) ? 8192 : int'(len);
    push_exp(base, n);
    first_rel = -1; last_rel = -1; done_rel = -1;
    busy_seen = 1'b0; valid_seen = 1'b0;
    base_cur = base; n_cur = n; addr_bad = 0;
    d0 = done_cnt; h0 = hs_cnt;
    @(posedge CLK); #1;
    START = 1'b1; BASE_ADDR = base; LEN = len;
    M_READY = (mode == 0) ? 1'b1 : 1'(($urandom % 2));
    @(posedge CLK); #1;
    s0 = cyc;
    addr_chk = check_addr;
    START = 1'b0;
    budget = n * 4 + 50;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      if (mode == 1) M_READY = 1'(($urandom % 2));
      if (k == poke_at) begin
        START = 1'b1; BASE_ADDR = 13'h0040; LEN = 14'd5;
      end else begin
        START = 1'b0;
      end
      @(posedge CLK); #1;
      k++;
    end
    START = 1'b0;
    if (done_cnt == d0) chk("frame_timeout", 32'(k), 32'(budget + 1));
    M_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    addr_chk = 1'b0;
    chk("done_pulse_count", 32'(done_cnt - d0), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("handshakes", 32'(hs_cnt - h0), 32'(n));
    chk("busy_after", 32'(BUSY), 32'd0);
    chk("ram_wen", 32'(RAM_WEN), 32'd0);
    if (check_addr) chk("ram_addr_seq", 32'(addr_bad), 32'd0);
    if (exp_first >= 0) chk("first_valid_cycle", 32'(first_rel), 32'(exp_first));
    if (exp_last  >= 0) chk("last_cycle", 32'(last_rel), 32'(exp_last));
    if (exp_done  >= 0) chk("done_cycle", 32'(done_rel), 32'(exp_done));
    exp_q.delete();
  endtask

  initial begin
    int d0;
    RST_N = 1'b0; START = 1'b0; BASE_ADDR = '0; LEN = '0; M_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy",   32'(BUSY),    32'd0);
    chk("rst_done",   32'(DONE),    32'd0);
    chk("rst_valid",  32'(M_VALID), 32'd0);
    chk("rst_last",   32'(M_LAST),  32'd0);
    chk("rst_data",   32'(M_DATA),  32'd0);
    chk("rst_addr",   32'(RAM_ADDR), 32'd0);
    chk("rst_wen",    32'(RAM_WEN), 32'd0);
    RST_N = 1'b1;
    M_READY = 1'b1;

    // Basic frame with exact latency.
    run_frame(13'h0100, 14'd16, 0, 1'b1, -1, 4, 19, 20);
    // Address wrap 8190, 8191, 0, 1.
    run_frame(13'd8190, 14'd4, 0, 1'b1, -1, 4, 7, 8);
    // Random backpressure.
    run_frame(13'h1F80, 14'd64, 1, 1'b0, -1, 4, -1, -1);
    // Empty frame.
    run_frame(13'h0010, 14'd0, 0, 1'b0, -1, -1, -1, 1);
    chk("len0_busy_never", 32'(busy_seen), 32'd0);
    chk("len0_valid_never", 32'(valid_seen), 32'd0);
    // START while busy is ignored.
    run_frame(13'h0200, 14'd8, 0, 1'b1, 3, 4, 11, 12);

    // Reset at cycle 10 of a LEN=32 frame.
    push_exp(13'h0300, 32);
    first_rel = -1; last_rel = -1; done_rel = -1;
    d0 = done_cnt;
    @(posedge CLK); #1;
    START = 1'b1; BASE_ADDR = 13'h0300; LEN = 14'd32; M_READY = 1'b1;
    @(posedge CLK); #1;
    s0 = cyc; START = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    chk("pre_rst_busy", 32'(BUSY), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("midrst_busy",  32'(BUSY),    32'd0);
    chk("midrst_valid", 32'(M_VALID), 32'd0);
    chk("midrst_last",  32'(M_LAST),  32'd0);
    chk("midrst_data",  32'(M_DATA),  32'd0);
    chk("midrst_addr",  32'(RAM_ADDR), 32'd0);
    chk("midrst_done",  32'(DONE),    32'd0);
    exp_q.delete();
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_no_last", 32'(last_rel), 32'hFFFF_FFFF);
    chk("postrst_valid",  32'(M_VALID), 32'd0);
    run_frame(13'h0123, 14'd6, 0, 1'b1, -1, 4, 9, 10);

    // Full-size frames, exact and clamped.
    run_frame(13'd5, 14'd8192, 0, 1'b1, -1, 4, 8195, 8196);
    run_frame(13'd5, 14'd9000, 0, 1'b1, -1, 4, 8195, 8196);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_frame_reader.md
# ram_frame_reader

Streaming read engine for one port of the 8K x 8 dual-port frame RAM (2-cycle registered read path). On a START command it reads LEN consecutive bytes from BASE_ADDR, wrapping modulo 8192. It presents the bytes on a valid/ready stream with a last-byte marker, so the data can feed serializers and packet builders. It is the consumer end of the frame buffer whose other port is written by the producer logic.

## Interface
Parameters:
- ADDR_W, 13, RAM address width (depth 2^ADDR_W bytes)
- DATA_W, 8, byte width
- RD_LAT, 2, cycles from address presented to data valid on RAM_DOUT
- FIFO_DEPTH, 4, output skid FIFO entries; must be >= RD_LAT+2

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  one-cycle command strobe; accepted only when BUSY=0
- BASE_ADDR  in  ADDR_W  first byte address, sampled with START
- LEN  in  ADDR_W+1  byte count, sampled with START; 0 = empty frame; >8192 clamped to 8192
- BUSY  out  1  frame in progress
- DONE  out  1  one-cycle pulse at frame completion
- RAM_ADDR  out  ADDR_W  read address to RAM port
- RAM_WEN  out  1  constant 0 (read only)
- RAM_DOUT  in  DATA_W  RAM read data, valid RD_LAT cycles after address
- M_DATA  out  DATA_W  stream data
- M_VALID  out  1  stream data valid
- M_READY  in  1  downstream accept
- M_LAST  out  1  qualifies final byte of frame

## Operation
- States: IDLE, READ, DRAIN.
- IDLE -> READ on START with clamped LEN > 0. Load the address counter with BASE_ADDR, load the issue counter with LEN, and load the delivery counter with LEN. Assert BUSY.
- START with LEN = 0 stays in IDLE and pulses DONE on the next cycle. BUSY never rises and no data is produced.
- READ: issue one read per cycle when (in-flight reads + FIFO occupancy) < FIFO_DEPTH. Issuing drives RAM_ADDR = address counter, increments the address modulo 2^ADDR_W (8191 -> 0), and decrements the issue counter.
- An RD_LAT-deep valid shift register tracks in-flight reads. When a tagged slot emerges, RAM_DOUT is written into the FIFO. The credit rule guarantees the FIFO never overflows.
- READ -> DRAIN when the issue counter reaches 0.
- DRAIN -> IDLE on the handshake (M_VALID & M_READY) of the byte where the delivery counter equals 1. DONE pulses the following cycle and BUSY falls in that same cycle.
- M_VALID = FIFO not empty. M_DATA = FIFO head. M_LAST = M_VALID and delivery counter = 1. The delivery counter decrements on each handshake.
- START while BUSY=1 is ignored, and no state changes.
- M_DATA/M_LAST hold stable while M_VALID=1 and M_READY=0.
- RAM_ADDR holds its last value when not issuing. RAM_WEN is always 0.

## Timing
- Reset values: BUSY=0, DONE=0, M_VALID=0, M_LAST=0, M_DATA=0, RAM_ADDR=0, RAM_WEN=0. FIFO, counters and valid pipe are cleared.
- Reset asserted mid-frame aborts immediately. In-flight and buffered data are discarded, with no DONE and no M_LAST.
- START sampled at edge 0 -> RAM_ADDR=BASE_ADDR in cycle 1 -> data on RAM_DOUT in cycle 1+RD_LAT -> M_VALID first high in cycle 2+RD_LAT (cycle 4 with defaults).
- With M_READY held 1: one byte per cycle, no bubbles. The last byte appears in cycle 3+LEN, DONE in cycle 4+LEN.
- Backpressure: issue stalls within one cycle of the credit limit. On M_READY rising, the output resumes the same cycle.
- Earliest START acceptance after a frame: the cycle DONE is high (BUSY=0).

## Test plan
- BASE=0x0100, LEN=16, RAM preloaded addr[7:0], M_READY=1 -> bytes 0x00..0x0F in cycles 4..19, M_LAST in cycle 19, DONE in cycle 20.
- BASE=8190, LEN=4 -> RAM_ADDR sequence 8190, 8191, 0, 1. Stream carries the corresponding bytes, M_LAST on the 4th byte.
- LEN=64 with random M_READY (50% duty) -> all 64 bytes in order with no loss or duplication, FIFO never overflows, stalled outputs stay stable.
- LEN=0 -> DONE pulse one cycle later, BUSY stays 0, M_VALID stays 0. START during a busy frame -> ignored, the frame completes unchanged.
- RST_N low at cycle 10 of a LEN=32 frame -> all outputs at reset values immediately. A new START after release runs a clean frame.
- LEN=8192 (and LEN=9000 clamped) from BASE=5 with M_READY=1 -> exactly 8192 bytes covering every address once, DONE in cycle 8196.
